// File: rtl/iob_fifo_sync_mc_pkg.sv
// Shared types and helpers for the multi-channel synchronous FIFO.
package iob_fifo_sync_mc_pkg;

    typedef struct packed {
        logic full;
        logic empty;
        logic afull;
        logic aempty;
    } ch_flags_t;

    localparam ch_flags_t FLAGS_RST = '{full: 1'b0, empty: 1'b1, afull: 1'b0, aempty: 1'b1};

    // A single channel still needs a one-bit channel field in the RAM address.
    function automatic int ch_w_f(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/iob_fifo_sync_mc_ch.sv
// One channel slice: pointers, level, registered flags, optional sticky error
// (IOB_FIFO_SYNC_MC_ERR_EN).
module iob_fifo_sync_mc_ch
    import iob_fifo_sync_mc_pkg::*;
#(
    parameter int ADDR_W     = 6,
    parameter int AFULL_LVL  = 2**ADDR_W - 2,
    parameter int AEMPTY_LVL = 2
) (
    input  logic              clk_i,
    input  logic              arst_n_i,
    input  logic              cke_i,
    input  logic              rst_i,
    input  logic              w_hit,
    input  logic              r_hit,
`ifdef IOB_FIFO_SYNC_MC_ERR_EN
    input  logic              w_err,
    input  logic              r_err,
    output logic              err,
`endif
    output logic [ADDR_W-1:0] wptr,
    output logic [ADDR_W-1:0] rptr,
    output logic [ADDR_W:0]   level,
    output ch_flags_t         flags
);

    localparam int LEVEL_W   = ADDR_W + 1;
    localparam int FIFO_SIZE = 2**ADDR_W;

    logic [LEVEL_W-1:0] level_nxt;
    ch_flags_t          flags_nxt;

    always_comb begin
        level_nxt = level;
        case ({w_hit, r_hit})
            2'b10:   level_nxt = level + LEVEL_W'(1);
            2'b01:   level_nxt = level - LEVEL_W'(1);
            default: level_nxt = level;
        endcase
        flags_nxt.full   = (level_nxt == LEVEL_W'(FIFO_SIZE));
        flags_nxt.empty  = (level_nxt == '0);
        flags_nxt.afull  = (level_nxt >= LEVEL_W'(AFULL_LVL));
        flags_nxt.aempty = (level_nxt <= LEVEL_W'(AEMPTY_LVL));
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
            flags <= FLAGS_RST;
        end else if (cke_i) begin
            if (rst_i) begin
                wptr  <= '0;
                rptr  <= '0;
                level <= '0;
                flags <= FLAGS_RST;
            end else begin
                if (w_hit) wptr <= wptr + ADDR_W'(1);
                if (r_hit) rptr <= rptr + ADDR_W'(1);
                level <= level_nxt;
                flags <= flags_nxt;
            end
        end
    end

`ifdef IOB_FIFO_SYNC_MC_ERR_EN
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i)
            err <= 1'b0;
        else if (cke_i) begin
            if (rst_i) err <= 1'b0;
            else       err <= err | w_err | r_err;
        end
    end
`endif

endmodule

// File: rtl/iob_fifo_sync_mc.sv
// Multi-channel synchronous FIFO over one external dual-port RAM.
// Optional sticky per-channel error output with IOB_FIFO_SYNC_MC_ERR_EN.
module iob_fifo_sync_mc
    import iob_fifo_sync_mc_pkg::*;
#(
    parameter  int N_CH       = 4,
    parameter  int DATA_W     = 32,
    parameter  int ADDR_W     = 6,
    parameter  int AFULL_LVL  = 2**ADDR_W - 2,
    parameter  int AEMPTY_LVL = 2,
    localparam int CH_W       = ch_w_f(N_CH),
    localparam int LEVEL_W    = ADDR_W + 1
) (
    input  logic                      clk_i,
    input  logic                      cke_i,
    input  logic                      arst_n_i,
    input  logic                      rst_i,
    input  logic                      w_en_i,
    input  logic [CH_W-1:0]           w_ch_i,
    input  logic [DATA_W-1:0]         w_data_i,
    input  logic                      r_en_i,
    input  logic [CH_W-1:0]           r_ch_i,
    output logic [DATA_W-1:0]         r_data_o,
    output logic                      r_valid_o,
    output logic [N_CH-1:0]           w_full_o,
    output logic [N_CH-1:0]           r_empty_o,
    output logic [N_CH-1:0]           almost_full_o,
    output logic [N_CH-1:0]           almost_empty_o,
    output logic [N_CH*LEVEL_W-1:0]   level_o,
    output logic                      ext_mem_clk_o,
    output logic                      ext_mem_w_en_o,
    output logic [CH_W+ADDR_W-1:0]    ext_mem_w_addr_o,
    output logic [DATA_W-1:0]         ext_mem_w_data_o,
    output logic                      ext_mem_r_en_o,
    output logic [CH_W+ADDR_W-1:0]    ext_mem_r_addr_o,
    input  logic [DATA_W-1:0]         ext_mem_r_data_i
`ifdef IOB_FIFO_SYNC_MC_ERR_EN
    ,output logic [N_CH-1:0]          err_o
`endif
);

    logic [N_CH-1:0][ADDR_W-1:0] wptr;
    logic [N_CH-1:0][ADDR_W-1:0] rptr;
    logic [N_CH-1:0]             w_hit;
    logic [N_CH-1:0]             r_hit;

    logic              w_in_rng, r_in_rng;
    logic              w_full_sel, r_empty_sel;
    logic              wa, ra;
    logic [ADDR_W-1:0] wptr_sel, rptr_sel;

    // Out-of-range channels look full/empty so they can never be accepted.
    always_comb begin
        w_in_rng    = ({1'b0, w_ch_i} < (CH_W+1)'(N_CH));
        r_in_rng    = ({1'b0, r_ch_i} < (CH_W+1)'(N_CH));
        w_full_sel  = w_in_rng ? w_full_o[w_ch_i]  : 1'b1;
        r_empty_sel = r_in_rng ? r_empty_o[r_ch_i] : 1'b1;
        wptr_sel    = w_in_rng ? wptr[w_ch_i] : '0;
        rptr_sel    = r_in_rng ? rptr[r_ch_i] : '0;
        wa          = cke_i & ~rst_i & w_en_i & ~w_full_sel;
        ra          = cke_i & ~rst_i & r_en_i & ~r_empty_sel;
    end

    assign ext_mem_clk_o    = clk_i;
    assign ext_mem_w_en_o   = wa;
    assign ext_mem_w_addr_o = {w_ch_i, wptr_sel};
    assign ext_mem_w_data_o = w_data_i;
    assign ext_mem_r_en_o   = ra;
    assign ext_mem_r_addr_o = {r_ch_i, rptr_sel};
    assign r_data_o         = ext_mem_r_data_i;

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i)
            r_valid_o <= 1'b0;
        else if (cke_i)
            r_valid_o <= ra;
    end

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        ch_flags_t          flags;
        logic [LEVEL_W-1:0] level;

        assign w_hit[k] = wa & (w_ch_i == CH_W'(k));
        assign r_hit[k] = ra & (r_ch_i == CH_W'(k));

        iob_fifo_sync_mc_ch #(
            .ADDR_W     (ADDR_W),
            .AFULL_LVL  (AFULL_LVL),
            .AEMPTY_LVL (AEMPTY_LVL)
        ) u_ch (
            .clk_i    (clk_i),
            .arst_n_i (arst_n_i),
            .cke_i    (cke_i),
            .rst_i    (rst_i),
            .w_hit    (w_hit[k]),
            .r_hit    (r_hit[k]),
`ifdef IOB_FIFO_SYNC_MC_ERR_EN
            .w_err    (w_en_i & (w_ch_i == CH_W'(k)) & w_full_o[k]),
            .r_err    (r_en_i & (r_ch_i == CH_W'(k)) & r_empty_o[k]),
            .err      (err_o[k]),
`endif
            .wptr     (wptr[k]),
            .rptr     (rptr[k]),
            .level    (level),
            .flags    (flags)
        );

        assign w_full_o[k]       = flags.full;
        assign r_empty_o[k]      = flags.empty;
        assign almost_full_o[k]  = flags.afull;
        assign almost_empty_o[k] = flags.aempty;
        assign level_o[k*LEVEL_W +: LEVEL_W] = level;
    end

endmodule

// File: tb/tb_iob_fifo_sync_mc.sv
// Directed bench for iob_fifo_sync_mc (N_CH=4, ADDR_W=6) with a behavioural RAM.
module tb_iob_fifo_sync_mc;

    logic        clk = 1'b0;
    logic        cke, arst_n, rst;
    logic        w_en, r_en;
    logic [1:0]  w_ch, r_ch;
    logic [31:0] w_data, r_data, mem_w_data, mem_r_data;
    logic        r_valid, mem_clk, mem_w_en, mem_r_en;
    logic [3:0]  w_full, r_empty, afull, aempty;
    logic [27:0] level;
    logic [7:0]  mem_w_addr, mem_r_addr;
`ifdef IOB_FIFO_SYNC_MC_ERR_EN
    logic [3:0]  err;
`endif

    int errs = 0;
    int checks = 0;

    always #5 clk = ~clk;

    iob_fifo_sync_mc dut (
        .clk_i(clk), .cke_i(cke), .arst_n_i(arst_n), .rst_i(rst),
        .w_en_i(w_en), .w_ch_i(w_ch), .w_data_i(w_data),
        .r_en_i(r_en), .r_ch_i(r_ch), .r_data_o(r_data), .r_valid_o(r_valid),
        .w_full_o(w_full), .r_empty_o(r_empty),
        .almost_full_o(afull), .almost_empty_o(aempty), .level_o(level),
        .ext_mem_clk_o(mem_clk), .ext_mem_w_en_o(mem_w_en),
        .ext_mem_w_addr_o(mem_w_addr), .ext_mem_w_data_o(mem_w_data),
        .ext_mem_r_en_o(mem_r_en), .ext_mem_r_addr_o(mem_r_addr),
        .ext_mem_r_data_i(mem_r_data)
`ifdef IOB_FIFO_SYNC_MC_ERR_EN
        ,.err_o(err)
`endif
    );

    logic [31:0] ram [256];
    always @(posedge mem_clk) begin
        if (mem_w_en) ram[mem_w_addr] <= mem_w_data;
        if (mem_r_en) mem_r_data <= ram[mem_r_addr];
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] lvl(input int k);
        return level[k*7 +: 7];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One cycle: drive requests, check accepts, then check the read return.
    task automatic cyc(input logic we, input logic [1:0] wc, input logic [31:0] wd,
                       input logic re, input logic [1:0] rc,
                       input logic exp_wa, input logic exp_ra, input logic [31:0] exp_rd);
        w_en = we; w_ch = wc; w_data = wd; r_en = re; r_ch = rc;
        #1;
        chk("w_accept", mem_w_en, exp_wa);
        chk("r_accept", mem_r_en, exp_ra);
        tick();
        chk("r_valid", r_valid, exp_ra);
        if (exp_ra) chk("r_data", r_data, exp_rd);
        w_en = 1'b0; r_en = 1'b0;
    endtask

    initial begin
        cke = 1'b1; arst_n = 1'b0; rst = 1'b0;
        w_en = 1'b0; r_en = 1'b0; w_ch = '0; r_ch = '0; w_data = '0;
        #22;
        chk("rst_empty", r_empty, 4'hF);
        chk("rst_aempty", aempty, 4'hF);
        chk("rst_full", w_full, 4'h0);
        chk("rst_afull", afull, 4'h0);
        chk("rst_valid", r_valid, 1'b0);
        chk("rst_level", level, 28'h0);
        arst_n = 1'b1;
        tick();

        // cke low: request dropped, nothing changes
        cke = 1'b0;
        cyc(1, 2, 32'hDEAD, 0, 0, 0, 0, 0);
        cke = 1'b1;
        chk("cke_level", lvl(2), 7'd0);

        // basic ordering on ch2
        for (int i = 0; i < 4; i++) cyc(1, 2, 32'hA0 + i, 0, 0, 1, 0, 0);
        chk("t1_level", lvl(2), 7'd4);
        chk("t1_empty", r_empty, 4'hB);
        chk("t1_aempty", aempty[2], 1'b0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 2, 0, 1, 32'hA0 + i);
        tick();
        chk("t1_valid_off", r_valid, 1'b0);
        chk("t1_empty_end", r_empty, 4'hF);
        chk("t1_level_end", level, 28'h0);

        // independent channels: ch1 writes, ch3 reads
        for (int i = 0; i < 3; i++) cyc(1, 1, 32'h11 + i, 1, 3, 1, 0, 0);
        cyc(1, 3, 32'h33, 1, 3, 1, 0, 0);
        cyc(1, 1, 32'h14, 1, 3, 1, 1, 32'h33);
        chk("t3_lvl1", lvl(1), 7'd4);
        chk("t3_lvl3", lvl(3), 7'd0);
        chk("t3_empty3", r_empty[3], 1'b1);
`ifdef IOB_FIFO_SYNC_MC_ERR_EN
        chk("t3_err", err, 4'h8);
`endif

        // same-channel read+write at level 5
        cyc(1, 1, 32'h15, 0, 0, 1, 0, 0);
        chk("t4_lvl5", lvl(1), 7'd5);
        cyc(1, 1, 32'h16, 1, 1, 1, 1, 32'h11);
        chk("t4_rw_lvl", lvl(1), 7'd5);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1, 1, 0, 1, 32'h12 + i);
        chk("t4_drain", r_empty[1], 1'b1);

        // fill ch0
        for (int i = 0; i < 64; i++) begin
            cyc(1, 0, 32'h100 + i, 0, 0, 1, 0, 0);
            if (i == 1)  chk("t2_aempty_l2", aempty[0], 1'b1);
            if (i == 2)  chk("t2_aempty_l3", aempty[0], 1'b0);
            if (i == 60) chk("t2_afull_l61", afull[0], 1'b0);
            if (i == 61) chk("t2_afull_l62", afull[0], 1'b1);
            if (i == 62) chk("t2_full_l63", w_full[0], 1'b0);
            if (i == 63) chk("t2_full_l64", w_full[0], 1'b1);
        end
        cyc(1, 0, 32'hBAD, 0, 0, 0, 0, 0);
        chk("t2_lvl64", lvl(0), 7'd64);
`ifdef IOB_FIFO_SYNC_MC_ERR_EN
        chk("t2_err", err, 4'h9);
`endif

        // full with simultaneous read+write: write dropped
        cyc(1, 0, 32'hBAD, 1, 0, 0, 1, 32'h100);
        chk("t4_full_lvl", lvl(0), 7'd63);
        chk("t4_full_drop", w_full[0], 1'b0);
        for (int i = 1; i < 64; i++) cyc(0, 0, 0, 1, 0, 0, 1, 32'h100 + i);
        chk("t4_ch0_empty", r_empty[0], 1'b1);

        // pointer wrap on ch1
        cyc(1, 1, 32'hC000_0000, 0, 0, 1, 0, 0);
        for (int i = 1; i < 200; i++)
            cyc(1, 1, 32'hC000_0000 + i, 1, 1, 1, 1, 32'hC000_0000 + i - 1);
        chk("t5_lvl1", lvl(1), 7'd1);
        cyc(0, 0, 0, 1, 1, 0, 1, 32'hC000_00C7);
        chk("t5_lvl0", lvl(1), 7'd0);

        // synchronous clear
        for (int i = 0; i < 10; i++) cyc(1, 0, 32'h200 + i, 0, 0, 1, 0, 0);
        chk("t6_lvl10", lvl(0), 7'd10);
        rst = 1'b1;
        cyc(1, 0, 32'h0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        chk("t6_rst_level", level, 28'h0);
        chk("t6_rst_empty", r_empty, 4'hF);
`ifdef IOB_FIFO_SYNC_MC_ERR_EN
        chk("t6_rst_err", err, 4'h0);
`endif

        // async reset mid-read
        cyc(1, 2, 32'h77, 0, 0, 1, 0, 0);
        cyc(1, 2, 32'h78, 0, 0, 1, 0, 0);
        r_en = 1'b1; r_ch = 2;
        tick();
        chk("t6_valid_pre", r_valid, 1'b1);
        #2 arst_n = 1'b0;
        #1;
        chk("t6_arst_valid", r_valid, 1'b0);
        chk("t6_arst_level", level, 28'h0);
        chk("t6_arst_empty", r_empty, 4'hF);
        r_en = 1'b0;
        #2 arst_n = 1'b1;
        tick();
        chk("t6_post_valid", r_valid, 1'b0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
